// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Vector order is z-major, then x, then y.
package sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {x, y, z} for a vector index laid out as {z, x, y}.
    function automatic logic [2:0] vec_to_xyz(input logic [IDX_W-1:0] idx);
        return {idx[1], idx[0], idx[2]};
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Per-vector hold timer: counts 0..HOLD_CYCLES-1 while enabled, wraps on terminal count.
// clr has priority over en and reloads zero.
module hold_counter #(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + CW'(1);
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input function block through all 8 vectors and captures its truth table.
// Optional golden-table comparator enabled by defining SWEEP_COMPARE_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | sweeping vectors, capturing on the last hold cycle of each
// DONE  | table complete, vector 7 held, start re-sweeps
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter logic [7:0]  EXPECTED_TABLE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   x,
    output logic                   y,
    output logic                   z,
    input  logic                   dut_out,
    output logic [IDX_W-1:0]       vec_idx,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] table_out,
    output logic                   mismatch
);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       vec_d;
    logic [NUM_VECTORS-1:0] table_d;
    logic [2:0]             xyz_d;
    logic                   cnt_clr, cnt_en, cnt_tc;

    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_idx;
        table_d = table_out;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    table_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            DRIVE: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    table_d[vec_idx] = dut_out;
                    if (vec_idx == IDX_W'(NUM_VECTORS - 1)) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_idx + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        xyz_d = vec_to_xyz(vec_d);
    end

    // Outputs load from next-state values so they stay aligned with vec_idx and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_idx   <= '0;
            table_out <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            z         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_idx   <= vec_d;
            table_out <= table_d;
            x         <= xyz_d[2];
            y         <= xyz_d[1];
            z         <= xyz_d[0];
            busy      <= (state_d == DRIVE);
            done      <= (state_d == DONE);
        end
    end

`ifdef SWEEP_COMPARE_EN
    logic mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= (state_d == DONE) && (table_d != EXPECTED_TABLE);
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED_TABLE;
    assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (HOLD_CYCLES 10 and 1)
// driven by directed and random function tables, checked against a behavioural model.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s   [2];
    logic       x_s       [2];
    logic       y_s       [2];
    logic       z_s       [2];
    logic       fo_s      [2];
    logic [2:0] vec_s     [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic [7:0] tbl_s     [2];
    logic       mism_s    [2];

    int         mode      [2];
    logic [7:0] lut       [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         unit;
        logic [7:0] tbl;
        int         k;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function block: 0 XOR, 1 AND, 2 constant 1, otherwise lookup indexed by {x,y,z}.
    function automatic logic func(input int m, input logic [7:0] l,
                                  input logic xi, input logic yi, input logic zi);
        case (m)
            0:       return xi ^ yi ^ zi;
            1:       return xi & yi & zi;
            2:       return 1'b1;
            default: return l[{xi, yi, zi}];
        endcase
    endfunction

    // Expected table: vector i is (z,x,y) = (i[2], i[1], i[0]).
    function automatic logic [7:0] model_table(input int m, input logic [7:0] l);
        logic [7:0] t;
        logic [2:0] v;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            v    = i[2:0];
            t[i] = func(m, l, v[1], v[0], v[2]);
        end
        return t;
    endfunction

    function automatic int hold_of(input int u);
        return (u == 0) ? 10 : 1;
    endfunction

    function automatic logic exp_mismatch(input int u, input logic [7:0] t);
`ifdef SWEEP_COMPARE_EN
        return (u == 0) ? (t != 8'h96) : (t != 8'h80);
`else
        return (u == 0) ? 1'b0 : (t == 8'h00 && t != 8'h00);
`endif
    endfunction

    function void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", nm, act, req, cyc);
        end
    endfunction

    assign fo_s[0] = func(mode[0], lut[0], x_s[0], y_s[0], z_s[0]);
    assign fo_s[1] = func(mode[1], lut[1], x_s[1], y_s[1], z_s[1]);

    truth_table_sweeper #(.HOLD_CYCLES(10), .EXPECTED_TABLE(8'h96)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
        .x(x_s[0]), .y(y_s[0]), .z(z_s[0]), .dut_out(fo_s[0]),
        .vec_idx(vec_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .table_out(tbl_s[0]), .mismatch(mism_s[0])
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED_TABLE(8'h80)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
        .x(x_s[1]), .y(y_s[1]), .z(z_s[1]), .dut_out(fo_s[1]),
        .vec_idx(vec_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .table_out(tbl_s[1]), .mismatch(mism_s[1])
    );

    // Monitor: per-cycle sequence checks while busy, scoreboard pop on each done rise.
    int   bc [2];
    logic pd [2];

    always @(negedge clk) begin
        int         h;
        logic [8:0] m9;
        logic [7:0] lo;
        exp_t       e;
        if (!rst_n) begin
            bc[0] = 0; bc[1] = 0;
            pd[0] = 1'b0; pd[1] = 1'b0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                h = hold_of(u);
                if (busy_s[u]) begin
                    check("busy_done_excl", {31'b0, done_s[u]}, 0);
                    check("vec_idx_seq", {29'b0, vec_s[u]}, bc[u] / h);
                    check("zxy_decode", {29'b0, z_s[u], x_s[u], y_s[u]}, {29'b0, vec_s[u]});
                    check("mismatch_busy", {31'b0, mism_s[u]}, 0);
                    if (q.size() > 0 && q[0].unit == u) begin
                        m9 = (9'h1 << vec_s[u]) - 9'h1;
                        lo = m9[7:0];
                        check("table_partial", {24'b0, tbl_s[u]}, {24'b0, q[0].tbl & lo});
                    end
                    bc[u]++;
                end
                if (done_s[u] && !pd[u]) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("done_unit", u, e.unit);
                        check("table_out", {24'b0, tbl_s[u]}, {24'b0, e.tbl});
                        check("done_latency", cyc - e.k, 1 + 8 * h);
                        check("busy_cycles", bc[u], 8 * h);
                        check("zxy_at_done", {29'b0, z_s[u], x_s[u], y_s[u]}, 32'd7);
                        check("mismatch_done", {31'b0, mism_s[u]}, {31'b0, exp_mismatch(u, e.tbl)});
                    end
                    bc[u] = 0;
                end
                pd[u] = done_s[u];
            end
        end
    end

    task automatic push_exp(input int u, input int k);
        exp_t e;
        e.unit = u;
        e.tbl  = model_table(mode[u], lut[u]);
        e.k    = k;
        q.push_back(e);
    endtask

    task automatic start_sweep(input int u);
        @(posedge clk); #1;
        start_s[u] = 1'b1;
        push_exp(u, cyc);
        @(posedge clk); #1;
        start_s[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        for (int n = 0; n < 8 * hold_of(u) + 40 && q.size() != 0; n++) @(posedge clk);
        check("sweep_complete", q.size(), 0);
        q.delete();
    endtask

    task automatic wait_vec(input int u, input logic [2:0] v);
        int n;
        n = 0;
        while (!(busy_s[u] && vec_s[u] == v) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_vector", n < 200, 1);
    endtask

    task automatic check_zero(input int u);
        check("rst_table", {24'b0, tbl_s[u]}, 0);
        check("rst_flags", {28'b0, busy_s[u], done_s[u], mism_s[u], 1'b0}, 0);
        check("rst_vec_xyz", {26'b0, vec_s[u], x_s[u], y_s[u], z_s[u]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        mode[0] = 0; mode[1] = 0;
        lut[0] = 8'h00; lut[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);

        // XOR, long hold.
        mode[0] = 0;
        start_sweep(0);
        wait_idle(0);

        // AND, single-cycle hold.
        mode[1] = 1;
        start_sweep(1);
        wait_idle(1);

        // Reset at vector 4, then a clean re-sweep.
        mode[0] = 0;
        start_sweep(0);
        wait_vec(0, 3'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_zero(0);
        check_zero(1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        start_sweep(0);
        wait_idle(0);

        // Start while busy is ignored; restart from DONE with constant 1.
        mode[0] = 0;
        start_sweep(0);
        wait_vec(0, 3'd3);
        @(posedge clk); #1 start_s[0] = 1'b1;
        @(posedge clk); #1 start_s[0] = 1'b0;
        wait_idle(0);
        mode[0] = 2;
        start_sweep(0);
        wait_idle(0);

        // start held high: DONE lasts one cycle, then a second sweep.
        mode[1] = 3;
        lut[1]  = 8'($urandom);
        @(posedge clk); #1;
        start_s[1] = 1'b1;
        push_exp(1, cyc);
        push_exp(1, cyc + 9);
        repeat (10) @(posedge clk);
        #1 start_s[1] = 1'b0;
        for (int n = 0; n < 40 && q.size() != 0; n++) @(posedge clk);
        check("back_to_back", q.size(), 0);
        q.delete();

        // Random function tables on both instances.
        for (int i = 0; i < 8; i++) begin
            int u;
            u = int'($urandom_range(0, 1));
            mode[u] = (i % 4 == 0) ? int'($urandom_range(0, 2)) : 3;
            lut[u]  = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            start_sweep(u);
            wait_idle(u);
        end

        repeat (5) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential stimulus/capture stage that wraps a 3-input combinational function block.
- Drives x, y, z through all 8 input combinations in a fixed order and holds each vector for HOLD_CYCLES clocks.
- Samples the block's single output on the last hold cycle of each vector and assembles an 8-bit truth table.
- Sits directly upstream and downstream of the function block: its x/y/z outputs feed the function inputs, and the function output returns on dut_out.

## Interface
Parameters:
- HOLD_CYCLES, 10, clocks each vector is held; legal range 1..255.
- EXPECTED_TABLE, 8'h00, golden truth table, bit i = expected output for vector i. Used only when SWEEP_COMPARE_EN is defined.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep; sampled in IDLE or DONE only.
- x  out  1  function input; equals vec_idx[1].
- y  out  1  function input; equals vec_idx[0].
- z  out  1  function input; equals vec_idx[2].
- dut_out  in  1  function output, combinational from x/y/z.
- vec_idx  out  3  index of the vector currently driven.
- busy  out  1  high in DRIVE.
- done  out  1  high in DONE; held until the next start or reset.
- table_out  out  8  captured truth table; bit i = dut_out for vector i.
- mismatch  out  1  table_out != EXPECTED_TABLE; valid only while done is high.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE, start=1:
  - Go to DRIVE; vec_idx=0; hold counter=0; table_out cleared to 0.
- DRIVE, each cycle:
  - If counter < HOLD_CYCLES-1: counter increments.
  - If counter == HOLD_CYCLES-1: table_out[vec_idx] <= dut_out.
  - After that capture, if vec_idx==7: go to DONE.
  - Otherwise: vec_idx increments and counter returns to 0.
- DONE:
  - x/y/z hold vector 7; table_out holds its value.
  - start=1 behaves exactly as start in IDLE: clears the table and re-sweeps.
- start is ignored while in DRIVE; there is no abort input.
- Sweep order is z-major, then x, then y: 000, 001, 010, 011, 100, 101, 110, 111 for (z,x,y).
- x, y, z are registered; they are a decode of vec_idx and are glitch-free at the clock edge.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Reset asserted mid-sweep returns the block to IDLE immediately and discards the partial table.
- Edge k asserts start; DRIVE begins at edge k+1 with vector 0.
- The capture for vector i happens at edge k+1+(i+1)·HOLD_CYCLES.
- done rises at edge k+1+8·HOLD_CYCLES; the sweep is 8·HOLD_CYCLES cycles long.
- HOLD_CYCLES=1: each vector lasts one cycle and is captured at the end of that cycle. dut_out must settle within one cycle.
- A vector change and a capture never occur on the same edge for the same index.
- start high continuously: in DONE, a new sweep begins on the next edge, one cycle of done per sweep.

## Configuration
- SWEEP_COMPARE_EN defined:
  - A comparator drives mismatch = done & (table_out != EXPECTED_TABLE), registered.
  - mismatch is valid in the same cycle that done is.
- SWEEP_COMPARE_EN undefined:
  - mismatch is tied to 0.
  - EXPECTED_TABLE is unused.
- The port list is identical in both builds.

## Structure
- Shared package sweep_pkg contains:
  - state enum {IDLE, DRIVE, DONE};
  - NUM_VECTORS=8;
  - IDX_W=3.
- Sub-module hold_counter:
  - Loadable counter with rst_n, clr, en, and terminal-count output tc at HOLD_CYCLES-1.
  - Width is $clog2(HOLD_CYCLES+1).
- The top level holds the FSM, the vec_idx register, the capture register and the optional comparator.

## Test plan
- Reset check: reset, then release with start=0 for 20 cycles -> all outputs 0, busy 0, done 0.
- XOR function, HOLD_CYCLES=10, start pulse -> table_out=8'h96, done exactly 81 cycles after the start edge, busy high for 80 cycles.
- 3-input AND, HOLD_CYCLES=1 -> table_out=8'h80, done 9 cycles after start; sequence of (z,x,y) over busy cycles is 000..111.
- Reset mid-sweep:
  - Stimulus: XOR function, assert rst_n=0 at vector 4, release, start again.
  - Required response: outputs 0 during reset; after restart, table_out=8'h96 with no stale bits.
- Start while busy plus restart from DONE:
  - Stimulus: pulse start at vector 3; later pulse start again from DONE with a constant-1 function.
  - Required response: the first start pulse has no effect; the sweep from DONE clears the table and ends with table_out=8'hFF.
- SWEEP_COMPARE_EN defined:
  - EXPECTED_TABLE=8'h96 with the XOR function -> mismatch 0.
  - EXPECTED_TABLE=8'h96 with the AND function -> mismatch 1 while done is high.
  - Undefined build, any case -> mismatch always 0.
